// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the memory-stage data responder.
package dmem_responder_pkg;

  localparam int unsigned DataWidth  = 32;
  localparam int unsigned WordOffset = 2;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StAck  = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data RAM: synchronous write, asynchronous read, contents not reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [DataWidth-1:0]           wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [DataWidth-1:0]           rdata
);

  logic [DataWidth-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data port responder with configurable wait states, stall and fault reporting.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemReqM,
  input  logic                 MemWriteM,
  input  logic [31:0]          ALUOutM,
  input  logic [DataWidth-1:0] WriteDataM,
  output logic [DataWidth-1:0] ReadDataM,
  output logic                 MemStallM,
  output logic                 MemFaultM
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  logic [IdxW-1:0]      idx_in;
  logic                 fault_in;
  logic                 we;
  logic [IdxW-1:0]      waddr;
  logic [IdxW-1:0]      raddr;
  logic [DataWidth-1:0] wdata;
  logic [DataWidth-1:0] rdata_arr;

  assign idx_in   = ALUOutM[IdxW+WordOffset-1:WordOffset];
  // Any set bit above the index field means the word address is >= DEPTH_WORDS.
  assign fault_in = (ALUOutM[WordOffset-1:0] != '0) | (|ALUOutM[31:IdxW+WordOffset]);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata_arr)
  );

  if (WAIT_STATES == 0) begin : g_comb
    assign we        = reset & MemReqM & MemWriteM & ~fault_in;
    assign waddr     = idx_in;
    assign raddr     = idx_in;
    assign wdata     = WriteDataM;
    assign MemStallM = 1'b0;
    assign ReadDataM = (reset & MemReqM & ~MemWriteM & ~fault_in) ? rdata_arr : '0;
    assign MemFaultM = reset & MemReqM & fault_in;
  end else begin : g_fsm
    state_e               state_q;
    logic [3:0]           cnt_q;
    logic [IdxW-1:0]      idx_q;
    logic [DataWidth-1:0] wdata_q;
    logic                 write_q;
    logic                 fault_q;
    logic                 ack;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        idx_q   <= '0;
        wdata_q <= '0;
        write_q <= 1'b0;
        fault_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (MemReqM) begin
              idx_q   <= idx_in;
              wdata_q <= WriteDataM;
              write_q <= MemWriteM;
              fault_q <= fault_in;
              if (WAIT_STATES > 1) begin
                state_q <= StWait;
                cnt_q   <= 4'(WAIT_STATES - 2);
              end else begin
                state_q <= StAck;
              end
            end
          end
          StWait: begin
            if (cnt_q == 4'd0) state_q <= StAck;
            else               cnt_q   <= cnt_q - 4'd1;
          end
          StAck:   state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end

    // Gating with reset keeps outputs quiet and drops the commit while reset is held.
    assign ack       = reset & (state_q == StAck);
    assign we        = ack & write_q & ~fault_q;
    assign waddr     = idx_q;
    assign raddr     = idx_q;
    assign wdata     = wdata_q;
    assign MemStallM = reset & (((state_q == StIdle) & MemReqM) | (state_q == StWait));
    assign ReadDataM = (ack & ~write_q & ~fault_q) ? rdata_arr : '0;
    assign MemFaultM = ack & fault_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench: four responders (WAIT_STATES 0..3) checked against a memory model and scoreboard.
module tb_dmem_responder;

  localparam int unsigned Depth = 64;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [4];
  logic        wr    [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];
  logic        stall [4];
  logic        fault [4];

  logic [31:0] model [4][Depth];
  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(Depth),
      .WAIT_STATES(g)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .MemReqM   (req[g]),
      .MemWriteM (wr[g]),
      .ALUOutM   (addr[g]),
      .WriteDataM(wdata[g]),
      .ReadDataM (rdata[g]),
      .MemStallM (stall[g]),
      .MemFaultM (fault[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete access on instance d; starts just after a rising edge, ends just after one.
  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input string tag);
    exp_t e;
    logic flt;
    int   stalls;
    bit   done;
    flt     = (a[1:0] != 2'b00) || (a[31:2] >= Depth);
    e.fault = flt;
    e.rdata = (!w && !flt) ? model[d][a[7:2]] : 32'h0;
    sb.push_back(e);
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall[d]) begin
        stalls++;
        check_eq({tag, "_stall_rd"}, rdata[d], 32'h0);
      end else begin
        done = 1'b1;
        e = sb.pop_front();
        check_eq({tag, "_rd"}, rdata[d], e.rdata);
        check_eq({tag, "_fault"}, {31'h0, fault[d]}, {31'h0, e.fault});
        check_eq({tag, "_stalls"}, stalls, d);
      end
    end
    if (!done) begin
      check_eq({tag, "_timeout"}, 32'h0, 32'h1);
      void'(sb.pop_front());
    end
    if (w && !flt) model[d][a[7:2]] = wd;
    @(posedge clk);
    #1;
    req[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic idle_check(input int d, input string tag);
    @(negedge clk);
    check_eq({tag, "_idle_rd"}, rdata[d], 32'h0);
    check_eq({tag, "_idle_flt"}, {31'h0, fault[d]}, 32'h0);
    check_eq({tag, "_idle_stall"}, {31'h0, stall[d]}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end

    // Reset state, including a request held high while reset is low.
    req[2] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", {31'h0, stall[2]}, 32'h0);
    check_eq("rst_rd", rdata[2], 32'h0);
    check_eq("rst_flt", {31'h0, fault[2]}, 32'h0);
    req[2] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int d = 0; d < 4; d++) idle_check(d, $sformatf("post_rst%0d", d));

    // Single-cycle path.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, "ws0_st");
    access(0, 1'b0, 32'h10, 32'h0, "ws0_ld");
    access(0, 1'b0, 32'h102, 32'h0, "ws0_flt");

    // Two wait states: load, back-to-back store then load, faults.
    access(2, 1'b1, 32'h20, 32'h12345678, "ws2_init");
    access(2, 1'b0, 32'h20, 32'h0, "ws2_ld");
    idle_check(2, "ws2_after");
    access(2, 1'b1, 32'h04, 32'hA5A5A5A5, "ws2_st");
    access(2, 1'b0, 32'h04, 32'h0, "ws2_raw");
    access(2, 1'b1, 32'h06, 32'hFFFFFFFF, "ws2_misal");
    access(2, 1'b0, 32'h04, 32'h0, "ws2_readback");
    access(2, 1'b0, 32'h100, 32'h0, "ws2_oor");
    access(2, 1'b1, 32'hFC, 32'h5555AAAA, "ws2_top");
    access(2, 1'b0, 32'hFC, 32'h0, "ws2_top_ld");

    // Three wait states: reset in the second stall cycle abandons the store.
    access(3, 1'b1, 32'h08, 32'h22222222, "ws3_init");
    req[3] = 1'b1; wr[3] = 1'b1; addr[3] = 32'h08; wdata[3] = 32'h11111111;
    @(negedge clk);
    check_eq("ws3_stall1", {31'h0, stall[3]}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check_eq("ws3_stall2", {31'h0, stall[3]}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("ws3_rst_stall", {31'h0, stall[3]}, 32'h0);
    check_eq("ws3_rst_flt", {31'h0, fault[3]}, 32'h0);
    @(posedge clk);
    #1;
    req[3] = 1'b0; wr[3] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    access(3, 1'b0, 32'h08, 32'h0, "ws3_abandon");

    // One wait state: eight consecutive loads.
    for (int i = 0; i < 8; i++)
      access(1, 1'b1, 32'(i * 4 + 32'h40), 32'hC0DE0000 + 32'(i), $sformatf("ws1_st%0d", i));
    for (int i = 0; i < 8; i++)
      access(1, 1'b0, 32'(i * 4 + 32'h40), 32'h0, $sformatf("ws1_ld%0d", i));
    idle_check(1, "ws1_after");

    check_eq("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the pipeline's memory-stage data port: it receives address, write data and write strobe from the M stage and returns ReadDataM.
- Models a word-organised data RAM with a configurable number of wait states.
- Raises MemStallM so the hazard unit can freeze F/D/E/M while an access is outstanding.
- Flags misaligned or out-of-range accesses through MemFaultM.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; must be a power of two and at least 2.
- WAIT_STATES, 2, stall cycles per access; range 0..15. 0 selects the single-cycle path.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- MemReqM  input  1  valid load or store in the M stage.
- MemWriteM  input  1  1 = store, 0 = load; ignored when MemReqM=0.
- ALUOutM  input  32  byte address.
- WriteDataM  input  32  store data.
- ReadDataM  output  32  load data; valid only in the completion cycle.
- MemStallM  output  1  access outstanding; the pipeline holds the M-stage inputs stable while this is high.
- MemFaultM  output  1  completion-cycle fault flag.

Behaviour:
- Index = ALUOutM[log2(DEPTH_WORDS)+1:2].
- Fault = (ALUOutM[1:0]!=0) | (ALUOutM[31:2] >= DEPTH_WORDS).
- A faulted access never writes, returns 0 and keeps normal timing.
- WAIT_STATES=0:
  - No FSM activity.
  - MemStallM=0 always.
  - ReadDataM = array[index] combinationally when MemReqM & ~MemWriteM & ~fault, else 0.
  - A store commits at the rising edge of its cycle.
  - MemFaultM = MemReqM & fault.
- WAIT_STATES>0: FSM with states IDLE, WAIT, ACK, and a 4-bit counter cnt.
  - IDLE:
    - MemStallM = MemReqM.
    - On MemReqM, latch index, write data, write flag and fault.
    - Go to WAIT with cnt=WAIT_STATES-2 if WAIT_STATES>1, else go to ACK.
  - WAIT:
    - MemStallM=1.
    - If cnt==0 go to ACK, else cnt--.
    - MemReqM is ignored here; inputs are guaranteed stable.
  - ACK:
    - MemStallM=0.
    - ReadDataM = array[latched index] for a non-faulted load, else 0.
    - MemFaultM = latched fault.
    - A non-faulted store commits at the rising edge ending ACK.
    - Next state is always IDLE.
  - Timing: exactly WAIT_STATES stall cycles; data returned in cycle WAIT_STATES+1 counted from first presentation.
  - Back-to-back accesses: the request presented in the cycle after ACK is a new access and starts in IDLE. There is no combined ACK-to-new-request shortcut.
  - Read-after-write to the same address in consecutive accesses returns the new data.
- Outputs outside the completion cycle: ReadDataM=0, MemFaultM=0.
- Reset asserted (low), at any time including mid-access:
  - state=IDLE, cnt=0, all latches=0.
  - MemStallM=0, ReadDataM=0, MemFaultM=0.
  - Pending stores are abandoned.
  - Array contents are NOT cleared.
- Release of reset is synchronous-safe: the first possible access starts in the first clock after release.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'b00, WAIT=2'b01, ACK=2'b10.
  - Data width 32 and the word-offset constant 2.
- One natural sub-module, dmem_array: DEPTH_WORDS x 32 RAM with synchronous write and asynchronous read, mirroring the register-file style.
- The FSM, counter and fault logic stay in dmem_responder.

Test Plan:
- WAIT_STATES=0: store 0xDEADBEEF to 0x10, then load 0x10 → MemStallM stays 0; ReadDataM=0xDEADBEEF in the load cycle.
- WAIT_STATES=2: load 0x20, pre-initialised to 0x12345678:
  - MemStallM=1 for exactly 2 cycles.
  - 3rd cycle: ReadDataM=0x12345678, MemFaultM=0.
  - 4th cycle: ReadDataM=0.
- WAIT_STATES=2: store 0xA5A5A5A5 to 0x04, then a new load of 0x04 in the cycle after ACK → the load also stalls 2 cycles and returns 0xA5A5A5A5.
- Faults:
  - Store to 0x06 (misaligned) → MemFaultM=1 in the completion cycle; word 0x04 unchanged on read-back.
  - Load from 0x100 with DEPTH_WORDS=64 → MemFaultM=1, ReadDataM=0.
- WAIT_STATES=3: store 0x11111111 to 0x08; assert reset during the 2nd stall cycle → MemStallM=0 immediately; after release, load 0x08 returns its old value (store abandoned).
- WAIT_STATES=1: 8 consecutive loads → MemStallM alternates 1,0 per access; each ACK returns the correct word.
